// File: rtl/fetch_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue_if
//   Bundles the instruction-memory request/response port and the decode-side
//   dequeue handshake of the fetch prefetch queue.
//
//   imem_addr   fetch -> mem     word-aligned request address
//   imem_rmask  fetch -> mem     4'hF = request this cycle, 4'h0 = idle
//   imem_rdata  mem   -> fetch   response data, valid with imem_resp
//   imem_resp   mem   -> fetch   one in-order response per pulse
//   deq_valid   fetch -> decode  head entry valid
//   deq_ready   decode-> fetch   consumer accepts head
//   deq_inst    fetch -> decode  head instruction word
//   deq_pc      fetch -> decode  head PC
//
//   master : the fetch unit side
//   slave  : the memory + decode environment side
// -----------------------------------------------------------------------------
interface fetch_prefetch_queue_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;

  modport master (
    output imem_addr,
    output imem_rmask,
    input  imem_rdata,
    input  imem_resp,
    output deq_valid,
    input  deq_ready,
    output deq_inst,
    output deq_pc
  );

  modport slave (
    input  imem_addr,
    input  imem_rmask,
    output imem_rdata,
    output imem_resp,
    input  deq_valid,
    output deq_ready,
    input  deq_inst,
    input  deq_pc
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
//   Instruction-fetch front end for the pipelined rv32i core. Issues pipelined
//   word requests to instruction memory, keeps up to MAX_INFLIGHT of them
//   outstanding, and buffers the returned words together with their PCs in a
//   DEPTH-entry FIFO feeding decode. A redirect flushes the FIFO, restarts
//   fetch at the new target and squashes responses still owed for the old
//   stream.
//
// Parameters
//   DEPTH         FIFO entries (power of 2, >= 2)
//   MAX_INFLIGHT  max outstanding imem requests (1..DEPTH)
//   RESET_PC      first fetch address after reset
//
// Ports
//   clk             clock
//   rst             synchronous, active-low reset
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch PC, bits [1:0] ignored
//   bus             imem request/response + dequeue handshake (master side)
//   occupancy       current FIFO entry count
// -----------------------------------------------------------------------------
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'h1eceb000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  fetch_prefetch_queue_if.master       bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      fetch_pc_q,  fetch_pc_d;
  logic [31:0]      resp_pc_q,   resp_pc_d;
  logic [INF_W-1:0] inflight_q,  inflight_d;
  logic [INF_W-1:0] squash_q,    squash_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [OCC_W-1:0] count_q,     count_d;
  entry_t           fifo_q [DEPTH];
  entry_t           fifo_d [DEPTH];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic        issue;
  logic        push;
  logic        pop;
  logic        drop_resp;
  logic        head_valid;
  logic [31:0] committed;
  logic [31:0] redirect_target;

  // Only the word address of a redirect matters.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[31:2], 2'b00};

  // Entries already in the FIFO plus live (non-squashed) requests that will
  // still land there. Issuing only while this stays below DEPTH guarantees
  // every accepted response has a free slot, so the FIFO cannot overflow.
  assign committed = 32'(count_q) + 32'(inflight_q) - 32'(squash_q);

  assign issue = rst && !redirect_valid
              && (32'(inflight_q) < MAX_INFLIGHT)
              && (committed < DEPTH);

  assign head_valid = rst && (count_q != '0);

  // A redirect overrides the response and dequeue paths for this cycle.
  assign drop_resp = bus.imem_resp && !redirect_valid && (squash_q != '0);
  assign push      = bus.imem_resp && !redirect_valid && (squash_q == '0);
  assign pop       = head_valid && bus.deq_ready && !redirect_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    squash_d   = squash_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fifo_d     = fifo_q;

    inflight_d = inflight_q + INF_W'(issue) - INF_W'(bus.imem_resp);

    if (redirect_valid) begin
      // Every request still owed after this cycle belongs to the old stream.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      squash_d   = inflight_q - INF_W'(bus.imem_resp);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (drop_resp) begin
        squash_d = squash_q - INF_W'(1);
      end

      if (push) begin
        fifo_d[wr_ptr_q] = '{pc: resp_pc_q, inst: bus.imem_rdata};
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        resp_pc_d        = resp_pc_q + 32'd4;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      count_d = count_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      squash_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO payload needs no reset: an entry is only visible once count_q
  // covers it, and count_q is reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fifo_q[i] <= fifo_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.imem_rmask = issue ? 4'hF : 4'h0;
  assign bus.imem_addr  = rst ? fetch_pc_q : RESET_PC;
  assign bus.deq_valid  = head_valid;
  assign bus.deq_inst   = fifo_q[rd_ptr_q].inst;
  assign bus.deq_pc     = fifo_q[rd_ptr_q].pc;
  assign occupancy      = rst ? count_q : '0;

endmodule
